dec_queue: RTL and testbench

Decoded-instruction queue between fetch and execute in the MIPS core. It accepts raw instruction/PC pairs on a valid/ready handshake, decodes each instruction once on entry, and stores the control bundle beside it. It tags delay-slot instructions and presents the oldest entry on a second valid/ready handshake. This lets fetch run ahead of decode stalls and replaces per-cycle stall gating with proper buffering and flush.

---
 rtl/dec_queue_pkg.sv | 53 +++++
 rtl/dec_queue_instr_ctrl_decode.sv | 93 +++++++++
 rtl/dec_queue.sv | 107 ++++++++++
 tb/tb_dec_queue.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dec_queue_pkg.sv
// Shared decode constants: opcode/funct/rt/rs codes, ERET word and the
// bit positions of the 12-bit control bundle.
package dec_queue_pkg;

  localparam int CTRL_W = 12;

  // control bundle bit positions (MSB first: branch ... invalid)
  localparam int CB_BRANCH     = 11;
  localparam int CB_JUMP       = 10;
  localparam int CB_JAL        = 9;
  localparam int CB_JR         = 8;
  localparam int CB_BAL        = 7;
  localparam int CB_ALU_SRC    = 6;
  localparam int CB_MEM_READ   = 5;
  localparam int CB_MEM_WRITE  = 4;
  localparam int CB_MEM_TO_REG = 3;
  localparam int CB_REG_WRITE  = 2;
  localparam int CB_REG_DST    = 1;
  localparam int CB_INVALID    = 0;

  // primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02,
                         OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE  = 6'h05,
                         OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI = 6'h08,
                         OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI     = 6'h0F, OP_COP0   = 6'h10, OP_LB   = 6'h20,
                         OP_LH      = 6'h21, OP_LW     = 6'h23, OP_LBU  = 6'h24,
                         OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH   = 6'h29,
                         OP_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA   = 6'h03,
                         FN_SLLV = 6'h04, FN_SRLV  = 6'h06, FN_SRAV  = 6'h07,
                         FN_JR   = 6'h08, FN_JALR  = 6'h09, FN_SYSCALL = 6'h0C,
                         FN_BREAK = 6'h0D, FN_MFHI = 6'h10, FN_MTHI  = 6'h11,
                         FN_MFLO = 6'h12, FN_MTLO  = 6'h13, FN_MULT  = 6'h18,
                         FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU  = 6'h1B,
                         FN_ADD  = 6'h20, FN_ADDU  = 6'h21, FN_SUB   = 6'h22,
                         FN_SUBU = 6'h23, FN_AND   = 6'h24, FN_OR    = 6'h25,
                         FN_XOR  = 6'h26, FN_NOR   = 6'h27, FN_SLT   = 6'h2A,
                         FN_SLTU = 6'h2B;

  // REGIMM rt codes
  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01,
                         RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

  // COP0 rs codes
  localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04;

  localparam logic [31:0] INSTR_ERET = 32'h4200_0018;

endpackage

// File: rtl/dec_queue_instr_ctrl_decode.sv
// Combinational MIPS decoder: raw instruction -> 12-bit control bundle.
// Unknown encodings yield only the invalid bit.
module dec_queue_instr_ctrl_decode
  import dec_queue_pkg::*;
(
  input  logic [31:0]       instr_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic [5:0]        op, fn;
  logic [4:0]        rs, rt;
  logic [CTRL_W-1:0] ctrl_c;
  logic              inv_c;

  assign op = instr_i[31:26];
  assign rs = instr_i[25:21];
  assign rt = instr_i[20:16];
  assign fn = instr_i[5:0];

  // classify the instruction and raise the matching control bits
  always_comb begin
    ctrl_c = '0;
    inv_c  = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_MFHI, FN_MFLO,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU: begin
            ctrl_c[CB_REG_WRITE] = 1'b1;
            ctrl_c[CB_REG_DST]   = 1'b1;
          end
          FN_JR: begin
            ctrl_c[CB_JUMP] = 1'b1;
            ctrl_c[CB_JR]   = 1'b1;
          end
          FN_JALR: begin
            ctrl_c[CB_JR]        = 1'b1;
            ctrl_c[CB_REG_WRITE] = 1'b1;
            ctrl_c[CB_REG_DST]   = 1'b1;
          end
          FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
          FN_SYSCALL, FN_BREAK: ;
          default: inv_c = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: ctrl_c[CB_BRANCH] = 1'b1;
          RT_BLTZAL, RT_BGEZAL: begin
            ctrl_c[CB_BRANCH]    = 1'b1;
            ctrl_c[CB_BAL]       = 1'b1;
            ctrl_c[CB_REG_WRITE] = 1'b1;
          end
          default: inv_c = 1'b1;
        endcase
      end
      OP_J: ctrl_c[CB_JUMP] = 1'b1;
      OP_JAL: begin
        ctrl_c[CB_JAL]       = 1'b1;
        ctrl_c[CB_REG_WRITE] = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: ctrl_c[CB_BRANCH] = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl_c[CB_ALU_SRC]   = 1'b1;
        ctrl_c[CB_REG_WRITE] = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctrl_c[CB_ALU_SRC]    = 1'b1;
        ctrl_c[CB_MEM_READ]   = 1'b1;
        ctrl_c[CB_MEM_TO_REG] = 1'b1;
        ctrl_c[CB_REG_WRITE]  = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl_c[CB_ALU_SRC]   = 1'b1;
        ctrl_c[CB_MEM_WRITE] = 1'b1;
      end
      OP_COP0: begin
        // ERET is the only accepted CO-format word; it needs no control bits
        if (rs == RS_MFC0) ctrl_c[CB_REG_WRITE] = 1'b1;
        else if (rs != RS_MTC0 && instr_i != INSTR_ERET) inv_c = 1'b1;
      end
      default: inv_c = 1'b1;
    endcase
    if (inv_c) begin
      ctrl_c             = '0;
      ctrl_c[CB_INVALID] = 1'b1;
    end
  end

  assign ctrl_o = ctrl_c;

endmodule

// File: rtl/dec_queue.sv
// Decoded-instruction queue: decodes on entry, tags delay slots and
// presents the oldest entry on a valid/ready handshake.
module dec_queue
  import dec_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic                       out_is_ds,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [31:0]       instr_mem_q [DEPTH];
  logic [PC_W-1:0]   pc_mem_q    [DEPTH];
  logic [CTRL_W-1:0] ctrl_mem_q  [DEPTH];
  logic              ds_mem_q    [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_cti_q, last_cti_d;

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_cti, full, empty, push, pop;

  dec_queue_instr_ctrl_decode u_instr_ctrl_decode (
    .instr_i (in_instr),
    .ctrl_o  (dec_ctrl)
  );

  assign dec_cti = dec_ctrl[CB_BRANCH] | dec_ctrl[CB_JUMP] | dec_ctrl[CB_JAL] | dec_ctrl[CB_JR];

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign out_valid = !empty;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = out_valid && out_ready && !flush;

  // next-state for pointers, occupancy and delay-slot tracking
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    last_cti_d = last_cti_q;
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      last_cti_d = 1'b0;
    end else begin
      if (push) begin
        tail_d     = tail_q + PTR_W'(1);
        // a CTI arms tagging of the next push; anything else disarms it
        last_cti_d = dec_cti;
      end
      if (pop) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      last_cti_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      last_cti_q <= last_cti_d;
    end
  end

  // entry storage write at the tail; contents are qualified by count
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[tail_q] <= in_instr;
      pc_mem_q[tail_q]    <= in_pc;
      ctrl_mem_q[tail_q]  <= dec_ctrl;
      ds_mem_q[tail_q]    <= last_cti_q;
    end
  end

  assign out_instr = empty ? '0 : instr_mem_q[head_q];
  assign out_pc    = empty ? '0 : pc_mem_q[head_q];
  assign out_ctrl  = empty ? '0 : ctrl_mem_q[head_q];
  assign out_is_ds = empty ? 1'b0 : ds_mem_q[head_q];
  assign count     = count_q;

endmodule

// File: tb/tb_dec_queue.sv
// Bench for dec_queue: directed scenarios then random traffic, all checked
// against a queue-based reference model with a table-style decoder.
module tb_dec_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready, out_is_ds;
  logic [31:0]       in_instr, out_instr;
  logic [PC_W-1:0]   in_pc, out_pc;
  logic [11:0]       out_ctrl;
  logic [CNT_W-1:0]  count;

  int checks = 0;
  int errors = 0;

  dec_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_ctrl(out_ctrl), .out_is_ds(out_is_ds), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [11:0]     ctrl;
    logic            is_ds;
  } entry_t;

  entry_t model_q[$];
  bit     ds_pending;

  localparam logic [31:0] I_ADDU  = 32'h0085_1021;
  localparam logic [31:0] I_BEQ   = 32'h1000_0004;
  localparam logic [31:0] I_ADDIU = 32'h2401_0001;
  localparam logic [31:0] I_J     = 32'h0800_0010;
  localparam logic [31:0] I_JAL   = 32'h0C00_0020;
  localparam logic [31:0] I_ORI   = 32'h3400_0001;

  // reference decoder: classify by field membership, then emit the bundle
  // {branch,jump,jal,jr,bal,alu_src,mem_read,mem_write,mem_to_reg,reg_write,reg_dst,invalid}
  function automatic logic [11:0] ref_ctrl(input logic [31:0] w);
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    bit br, jp, jl, jrr, bl, as, mr, mw, mtr, rw, rd, inv;
    op = w[31:26]; fn = w[5:0]; rs = w[25:21]; rt = w[20:16];
    {br, jp, jl, jrr, bl, as, mr, mw, mtr, rw, rd, inv} = '0;
    if (op == 6'd0) begin
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                     [6'h20:6'h27], 6'h2A, 6'h2B}) begin rw = 1; rd = 1; end
      else if (fn == 6'h08) begin jp = 1; jrr = 1; end
      else if (fn == 6'h09) begin jrr = 1; rw = 1; rd = 1; end
      else if (!(fn inside {6'h0C, 6'h0D, 6'h11, 6'h13, [6'h18:6'h1B]})) inv = 1;
    end else if (op == 6'd1) begin
      if (rt inside {5'h00, 5'h01}) br = 1;
      else if (rt inside {5'h10, 5'h11}) begin br = 1; bl = 1; rw = 1; end
      else inv = 1;
    end else if (op == 6'd2) jp = 1;
    else if (op == 6'd3) begin jl = 1; rw = 1; end
    else if (op inside {[6'd4:6'd7]}) br = 1;
    else if (op inside {[6'd8:6'd15]}) begin as = 1; rw = 1; end
    else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
      as = 1; mr = 1; mtr = 1; rw = 1;
    end else if (op inside {6'h28, 6'h29, 6'h2B}) begin as = 1; mw = 1; end
    else if (op == 6'h10) begin
      if (rs == 5'd0) rw = 1;
      else if (rs != 5'd4 && w != 32'h4200_0018) inv = 1;
    end else inv = 1;
    if (inv) return 12'h001;
    return {br, jp, jl, jrr, bl, as, mr, mw, mtr, rw, rd, 1'b0};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [5:0]  ops [14];
    int          r;
    ops = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h0F,
            6'h20, 6'h23, 6'h25, 6'h28, 6'h2B, 6'h3F};
    w = $urandom;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2: w[31:26] = 6'h00;
      3:       w[31:26] = 6'h01;
      4, 5, 6: w[31:26] = ops[$urandom_range(0, 13)];
      7: begin
        w[31:26] = 6'h10;
        w[25:21] = (w[0]) ? 5'h00 : ((w[1]) ? 5'h04 : w[25:21]);
      end
      8:       w = 32'h4200_0018;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    entry_t h;
    chk("count", 64'(count), 64'(model_q.size()));
    chk("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(model_q.size() < DEPTH));
    if (model_q.size() != 0) h = model_q[0];
    else h = '{instr: '0, pc: '0, ctrl: '0, is_ds: 1'b0};
    chk("out_instr", 64'(out_instr), 64'(h.instr));
    chk("out_pc", 64'(out_pc), 64'(h.pc));
    chk("out_ctrl", 64'(out_ctrl), 64'(h.ctrl));
    chk("out_is_ds", 64'(out_is_ds), 64'(h.is_ds));
  endtask

  // drive one cycle, advance the model, then compare just after the edge
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit rdy, input bit fl, input bit rs);
    bit     do_push, do_pop;
    entry_t e;
    in_valid = v; in_instr = ins; in_pc = pc[PC_W-1:0];
    out_ready = rdy; flush = fl; rst = rs;
    @(posedge clk);
    if (rs || fl) begin
      model_q.delete();
      ds_pending = 0;
    end else begin
      do_pop  = rdy && model_q.size() > 0;
      do_push = v && model_q.size() < DEPTH;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.instr = ins; e.pc = pc[PC_W-1:0]; e.ctrl = ref_ctrl(ins);
        e.is_ds = ds_pending;
        ds_pending = |e.ctrl[11:8];
        model_q.push_back(e);
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    ds_pending = 0;
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = '0; in_pc = '0;

    // reset
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);

    // ADDU into empty queue
    step(1, I_ADDU, 32'h100, 0, 0, 0);
    chk("addu_valid", 64'(out_valid), 64'd1);
    chk("addu_ctrl", 64'(out_ctrl), 64'h006);
    chk("addu_count", 64'(count), 64'd1);
    chk("addu_pc", 64'(out_pc), 64'h100);
    step(0, 0, 0, 1, 0, 0);

    // BEQ then ADDIU: ADDIU sits in the delay slot
    step(1, I_BEQ, 32'h200, 0, 0, 0);
    step(1, I_ADDIU, 32'h204, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("addiu_ds", 64'(out_is_ds), 64'd1);
    chk("addiu_ctrl", 64'(out_ctrl), 64'h044);
    step(0, 0, 0, 1, 0, 0);

    // J, JAL, ADDU: JAL tagged and keeps tracking armed for ADDU
    step(1, I_J, 32'h300, 0, 0, 0);
    step(1, I_JAL, 32'h304, 0, 0, 0);
    step(1, I_ADDU, 32'h308, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("jal_ds", 64'(out_is_ds), 64'd1);
    chk("jal_ctrl", 64'(out_ctrl), 64'h204);
    step(0, 0, 0, 1, 0, 0);
    chk("after_jal_ds", 64'(out_is_ds), 64'd1);
    step(0, 0, 0, 1, 0, 0);

    // fill, then push+pop while full: push refused
    step(1, I_ADDU, 32'h400, 0, 0, 0);
    step(1, I_ADDU, 32'h404, 0, 0, 0);
    step(1, I_ADDU, 32'h408, 0, 0, 0);
    step(1, I_BEQ, 32'h40C, 0, 0, 0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    step(1, I_ORI, 32'h410, 1, 0, 0);
    chk("full_pushpop_count", 64'(count), 64'd3);

    // flush beats push and pop; tracking cleared
    step(1, I_ORI, 32'h999, 1, 1, 0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    step(1, I_ADDU, 32'h500, 0, 0, 0);
    chk("post_flush_ds", 64'(out_is_ds), 64'd0);
    chk("post_flush_instr", 64'(out_instr), 64'(I_ADDU));
    step(0, 0, 0, 0, 1, 0);

    // decode boundaries
    step(1, 32'hFC00_0000, 32'h600, 0, 0, 0);
    chk("unk_op_ctrl", 64'(out_ctrl), 64'h001);
    step(0, 0, 0, 0, 1, 0);
    step(1, 32'h4200_0018, 32'h604, 0, 0, 0);
    chk("eret_ctrl", 64'(out_ctrl), 64'h000);
    step(0, 0, 0, 0, 1, 0);
    step(1, 32'h4200_0019, 32'h608, 0, 0, 0);
    chk("bad_cop0_ctrl", 64'(out_ctrl), 64'h001);
    step(0, 0, 0, 0, 1, 0);

    // rst mid-stream
    step(1, I_BEQ, 32'h700, 0, 0, 0);
    step(1, I_ADDU, 32'h704, 0, 0, 0);
    step(1, I_ADDU, 32'h708, 1, 0, 1);
    chk("midrst_count", 64'(count), 64'd0);
    step(1, I_ADDU, 32'h70C, 0, 0, 0);
    chk("midrst_ds", 64'(out_is_ds), 64'd0);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, gen_instr(), $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
